// File: rtl/hilo_unit.sv
// hilo_unit: multiply/divide responder that owns the HI/LO registers.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage.
// Mul/div run for 32 iteration cycles plus one fixup cycle. HI/LO are only
// written when the operation completes, so an abort leaves them untouched.
//
// Ports:
//   clock      system clock, all state updates on the rising edge
//   reset_n    synchronous active-low reset
//   req_valid  request strobe, one cycle per request
//   req_op     0=MULTU 1=MULT 2=DIVU 3=DIV 4=MTHI 5=MTLO 6,7=ignored
//   req_a      rs operand (multiplicand / dividend / MTHI-MTLO data)
//   req_b      rt operand (multiplier / divisor)
//   abort      cancel any in-flight op and drop a same-cycle request
//   busy       operation in flight
//   hi, lo     architectural HI/LO
//   done       one-cycle pulse in the first cycle a new mul/div result is visible
module hilo_unit #(
    parameter int unsigned debug = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        abort,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFixup} state_e;

    localparam logic [2:0] OpMultu = 3'd0;
    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpDivu  = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    // debug only gates simulation tracing; it never changes the logic.
    if (debug != 0) begin : g_debug
    end

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        is_div_q, is_div_d;
    logic        b_zero_q, b_zero_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        accept;
    logic        signed_op;
    logic [31:0] mag_a, mag_b;
    logic [32:0] rem_shift, rem_diff;
    logic [63:0] prod_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        is_div_d  = is_div_q;
        b_zero_d  = b_zero_q;
        a_raw_d   = a_raw_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        signed_op = 1'b0;
        mag_a     = '0;
        mag_b     = '0;
        rem_shift = '0;
        rem_diff  = '0;
        prod_fix  = '0;
        accept    = req_valid && (state_q == StIdle) && !abort;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (req_op)
                        OpMultu, OpMult, OpDivu, OpDiv: begin
                            signed_op = req_op[0];
                            sign_a_d  = signed_op & req_a[31];
                            sign_b_d  = signed_op & req_b[31];
                            mag_a     = sign_a_d ? -req_a : req_a;
                            mag_b     = sign_b_d ? -req_b : req_b;
                            is_div_d  = req_op[1];
                            b_zero_d  = (req_b == '0);
                            a_raw_d   = req_a;
                            cnt_d     = '0;
                            mcand_d   = {32'd0, mag_a};
                            mplier_d  = mag_b;
                            prod_d    = '0;
                            rem_d     = '0;
                            quo_d     = mag_a;
                            divisor_d = mag_b;
                            state_d   = req_op[1] ? StDiv : StMul;
                        end
                        OpMthi:  hi_d = req_a;
                        OpMtlo:  lo_d = req_a;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = StFixup;
                end
            end
            StDiv: begin
                // Partial remainder is widened to 33 bits for the trial subtract;
                // bit 32 of the difference is the borrow.
                rem_shift = {rem_q, quo_q[31]};
                rem_diff  = rem_shift - {1'b0, divisor_q};
                if (!rem_diff[32]) begin
                    rem_d = rem_diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
                    hi_d     = prod_fix[63:32];
                    lo_d     = prod_fix[31:0];
                end else if (b_zero_q) begin
                    lo_d = '1;
                    hi_d = a_raw_q;
                end else begin
                    lo_d = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                    hi_d = sign_a_q ? -rem_q : rem_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything, including the fixup write.
        if (abort) begin
            state_d = StIdle;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            is_div_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            a_raw_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            is_div_q  <= is_div_d;
            b_zero_q  <= b_zero_d;
            a_raw_q   <= a_raw_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule
